// File: rtl/pet_kbd_pkg.sv
// Shared constants and types for the PET PS/2 keyboard front end.
// Matrix geometry, special scan codes, keymap entry and receiver states.
package pet_kbd_pkg;

  localparam int KEY_ROWS = 10;
  localparam int KEY_COLS = 8;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_BAT = 8'hAA;
  localparam logic [7:0] SC_ACK = 8'hFA;
  localparam logic [7:0] SC_OV0 = 8'h00;
  localparam logic [7:0] SC_OV1 = 8'hFF;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } key_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_RX
  } rx_state_t;

  function automatic key_entry_t km(
    input logic [3:0] r,
    input logic [2:0] c
  );
    km = '{hit: 1'b1, row: r, col: c};
  endfunction

endpackage

// File: rtl/pet_keymap.sv
// Combinational PS/2 set-2 scan code -> PET graphics matrix position.
// Ports: i_ext (E0 prefix seen), i_code; o_hit, o_row, o_col.
module pet_keymap
  import pet_kbd_pkg::*;
(
  input  logic       i_ext,
  input  logic [7:0] i_code,
  output logic       o_hit,
  output logic [3:0] o_row,
  output logic [2:0] o_col
);

  key_entry_t w_e;

  always_comb begin
    w_e = '0;
    case ({i_ext, i_code})
      9'h015: w_e = km(4'd2, 3'd0);
      9'h024: w_e = km(4'd2, 3'd1);
      9'h02C: w_e = km(4'd2, 3'd2);
      9'h03C: w_e = km(4'd2, 3'd3);
      9'h044: w_e = km(4'd2, 3'd4);
      9'h01D: w_e = km(4'd3, 3'd0);
      9'h02D: w_e = km(4'd3, 3'd1);
      9'h035: w_e = km(4'd3, 3'd2);
      9'h043: w_e = km(4'd3, 3'd3);
      9'h04D: w_e = km(4'd3, 3'd4);
      9'h01C: w_e = km(4'd4, 3'd0);
      9'h023: w_e = km(4'd4, 3'd1);
      9'h034: w_e = km(4'd4, 3'd2);
      9'h03B: w_e = km(4'd4, 3'd3);
      9'h04B: w_e = km(4'd4, 3'd4);
      9'h01B: w_e = km(4'd5, 3'd0);
      9'h02B: w_e = km(4'd5, 3'd1);
      9'h033: w_e = km(4'd5, 3'd2);
      9'h042: w_e = km(4'd5, 3'd3);
      9'h01A: w_e = km(4'd6, 3'd0);
      9'h021: w_e = km(4'd6, 3'd1);
      9'h032: w_e = km(4'd6, 3'd2);
      9'h03A: w_e = km(4'd6, 3'd3);
      9'h05A: w_e = km(4'd6, 3'd5);
      9'h022: w_e = km(4'd7, 3'd0);
      9'h02A: w_e = km(4'd7, 3'd1);
      9'h031: w_e = km(4'd7, 3'd2);
      9'h041: w_e = km(4'd7, 3'd3);
      9'h012: w_e = km(4'd8, 3'd0);
      9'h059: w_e = km(4'd8, 3'd5);
      9'h029: w_e = km(4'd9, 3'd2);
      9'h175: w_e = km(4'd1, 3'd7);
      {1'b0, SC_BAT},
      {1'b0, SC_ACK}: w_e = '0;
      default: w_e = '0;
    endcase
  end

  assign o_hit = w_e.hit;
  assign o_row = w_e.row;
  assign o_col = w_e.col;

endmodule

// File: rtl/pet2001ps2_keyboard.sv
// PS/2 receiver, scan-code decoder and 10x8 PET key matrix for PIA1.
// Ports: clk, reset_n, ps2_clk/ps2_data in; keyrow in; keyin, key_strobe, frame_err out.
module pet2001ps2_keyboard
  import pet_kbd_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] keyrow,
  output logic [7:0] keyin,
  output logic       key_strobe,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_fall;
  logic                   w_dat;

  rx_state_t   r_state;
  rx_state_t   w_state_n;
  logic [3:0]  r_bitcnt;
  logic [8:0]  r_sr;
  logic [TW-1:0] r_tmo;
  logic        w_accept;
  logic        w_err;
  logic        w_abort;

  logic [7:0]  r_code;
  logic        r_code_v;
  logic        r_brk;
  logic        r_ext;
  logic        r_key_strobe;
  logic        r_frame_err;
  logic [7:0]  r_keyin;
  logic [KEY_COLS-1:0] r_matrix [KEY_ROWS];
  logic [KEY_COLS-1:0] w_row_bits;

  logic        w_hit;
  logic [3:0]  w_row;
  logic [2:0]  w_col;

  // Synchronisers reset to the idle-high bus level so no false fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_dat  = r_dat_sync[SYNC_STAGES-1];

  // A fall always wins over a timeout on the same cycle.
  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_err     = 1'b0;
    w_abort   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_fall && !w_dat) w_state_n = ST_RX;
      end
      ST_RX: begin
        if (w_fall) begin
          if (r_bitcnt == 4'd9) begin
            w_state_n = ST_IDLE;
            if ((^r_sr) && w_dat) w_accept = 1'b1;
            else w_err = 1'b1;
          end
        end else if (r_tmo == TMO_MAX) begin
          w_state_n = ST_IDLE;
          w_err     = 1'b1;
          w_abort   = 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= '0;
      r_sr        <= '0;
      r_tmo       <= '0;
      r_code      <= '0;
      r_code_v    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_frame_err <= w_err;
      r_code_v    <= w_accept;
      if (w_accept) r_code <= r_sr[7:0];
      if (w_state_n != ST_RX) begin
        r_bitcnt <= '0;
        r_tmo    <= '0;
      end else if (r_state == ST_RX) begin
        if (w_fall) begin
          r_tmo    <= '0;
          r_bitcnt <= r_bitcnt + 4'd1;
          r_sr     <= {w_dat, r_sr[8:1]};
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end
    end
  end

  pet_keymap u_map (
    .i_ext  (r_ext),
    .i_code (r_code),
    .o_hit  (w_hit),
    .o_row  (w_row),
    .o_col  (w_col)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_brk        <= 1'b0;
      r_ext        <= 1'b0;
      r_key_strobe <= 1'b0;
      for (int r = 0; r < KEY_ROWS; r++) r_matrix[r] <= '0;
    end else begin
      r_key_strobe <= 1'b0;
      if (w_abort) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else if (r_code_v) begin
        unique case (1'b1)
          (r_code == SC_EXT): r_ext <= 1'b1;
          (r_code == SC_BRK): r_brk <= 1'b1;
          default: begin
            if (r_code == SC_OV0 || r_code == SC_OV1) begin
              for (int r = 0; r < KEY_ROWS; r++) r_matrix[r] <= '0;
            end else if (w_hit) begin
              r_matrix[w_row][w_col] <= ~r_brk;
            end
            r_key_strobe <= 1'b1;
            r_brk        <= 1'b0;
            r_ext        <= 1'b0;
          end
        endcase
      end
    end
  end

  // Rows 10..15 select nothing and read back all released.
  always_comb begin
    w_row_bits = '0;
    for (int r = 0; r < KEY_ROWS; r++)
      if (keyrow == 4'(r)) w_row_bits = r_matrix[r];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_keyin <= 8'hFF;
    else          r_keyin <= ~w_row_bits;
  end

  assign keyin      = r_keyin;
  assign key_strobe = r_key_strobe;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_pet2001ps2_keyboard.sv
// Bench for pet2001ps2_keyboard: frame table plus hand sequences.
// Strobe/error events are checked against a queue of expected events.
`timescale 1ns/1ps
module tb_pet2001ps2_keyboard;

  localparam int  TMO  = 8192;
  localparam time HALF = 200;

  localparam logic [1:0] EV_NONE = 2'd0;
  localparam logic [1:0] EV_STB  = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] keyrow = 4'd0;
  logic [7:0] keyin;
  logic       key_strobe;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] q_ev [$];

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic [3:0] row;
    logic [7:0] exp;
    logic [1:0] ev;
  } vec_t;

  vec_t vt [15];

  pet2001ps2_keyboard #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keyrow     (keyrow),
    .keyin      (keyin),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    #HALF;
    ps2_clk = 1'b0;
    #HALF;
    ps2_clk = 1'b1;
  endtask

  // kind: 1 good frame, 2 parity flipped. nbits < 11 leaves a stalled frame.
  task automatic send(input logic [7:0] c, input logic bad,
                      input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^c) ^ bad, c, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    #HALF;
  endtask

  task automatic chk_row(input logic [3:0] r, input logic [7:0] e,
                         input string nm);
    @(negedge clk);
    keyrow = r;
    @(negedge clk);
    @(negedge clk);
    chk(nm, 32'(keyin), 32'(e));
  endtask

  task automatic push(input logic [1:0] e);
    if (e != EV_NONE) q_ev.push_back(e);
  endtask

  initial begin
    vt[0]  = '{1, 8'h1C, 4'd4,  8'hFE, EV_STB};
    vt[1]  = '{1, 8'hF0, 4'd4,  8'hFE, EV_NONE};
    vt[2]  = '{1, 8'h1C, 4'd4,  8'hFF, EV_STB};
    vt[3]  = '{1, 8'h12, 4'd8,  8'hFE, EV_STB};
    vt[4]  = '{1, 8'h59, 4'd8,  8'hDE, EV_STB};
    vt[5]  = '{0, 8'h00, 4'd12, 8'hFF, EV_NONE};
    vt[6]  = '{2, 8'h1C, 4'd4,  8'hFF, EV_ERR};
    vt[7]  = '{1, 8'hE0, 4'd1,  8'hFF, EV_NONE};
    vt[8]  = '{1, 8'h75, 4'd1,  8'h7F, EV_STB};
    vt[9]  = '{1, 8'hE0, 4'd1,  8'h7F, EV_NONE};
    vt[10] = '{1, 8'hF0, 4'd1,  8'h7F, EV_NONE};
    vt[11] = '{1, 8'h75, 4'd1,  8'hFF, EV_STB};
    vt[12] = '{1, 8'hAA, 4'd8,  8'hDE, EV_STB};
    vt[13] = '{1, 8'hFA, 4'd8,  8'hDE, EV_STB};
    vt[14] = '{1, 8'h00, 4'd8,  8'hFF, EV_STB};

    #23;
    chk("rst_keyin", 32'(keyin), 32'hFF);
    chk("rst_strobe", 32'(key_strobe), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    reset_n = 1'b1;

    fork
      forever begin
        logic [1:0] got;
        logic [1:0] exp;
        @(negedge clk);
        if (reset_n && (key_strobe || frame_err)) begin
          got = {frame_err, key_strobe};
          n_cmp++;
          if (q_ev.size() == 0) begin
            n_bad++;
            $display("FAIL event: got %0d, want none", got);
          end else begin
            exp = q_ev.pop_front();
            if (got !== exp) begin
              n_bad++;
              $display("FAIL event: got %0d, want %0d", got, exp);
            end
          end
        end
      end
    join_none

    for (int i = 0; i < 15; i++) begin
      if (vt[i].kind != 0) begin
        push(vt[i].ev);
        send(vt[i].code, vt[i].kind == 2, 11);
      end
      chk_row(vt[i].row, vt[i].exp, $sformatf("vec%0d", i));
    end

    // Timeout mid-frame must also drop a pending E0 prefix.
    push(EV_NONE);
    send(8'hE0, 1'b0, 11);
    push(EV_ERR);
    send(8'h1C, 1'b0, 6);
    #(TMO * 10 + 1000);
    chk("tmo_idle", 32'(dut.r_state), 32'(0));
    push(EV_STB);
    send(8'h75, 1'b0, 11);
    chk_row(4'd1, 8'hFF, "tmo_ext_clr");
    push(EV_STB);
    send(8'h29, 1'b0, 11);
    chk_row(4'd9, 8'hFB, "tmo_next");

    // A fall with data high while idle is not a start bit.
    ps2_bit(1'b1);
    push(EV_STB);
    send(8'h1C, 1'b0, 11);
    chk_row(4'd4, 8'hFE, "idle_glitch");

    // keyin follows keyrow exactly one clock later.
    @(negedge clk);
    keyrow = 4'd9;
    #1;
    chk("lat_old", 32'(keyin), 32'hFE);
    @(posedge clk);
    #1;
    chk("lat_new", 32'(keyin), 32'hFB);

    // Reset mid-frame with keys held in rows 4 and 9.
    send(8'h5A, 1'b0, 4);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async", 32'(keyin), 32'hFF);
    #20;
    reset_n = 1'b1;
    chk_row(4'd4, 8'hFF, "rst_row4");
    chk_row(4'd9, 8'hFF, "rst_row9");
    push(EV_STB);
    send(8'h1C, 1'b0, 11);
    chk_row(4'd4, 8'hFE, "rst_next");

    #1000;
    chk("sb_drain", 32'(q_ev.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
